// File: rtl/vend_sequencer.sv
// Soda machine vend controller: coin credit, select-to-column mapping,
// one-motor-at-a-time CAM-counted vends and a per-phase jam watchdog.
module vend_sequencer #(
    parameter int NCOL       = 8,
    parameter int CAM_CYCLES = 2,
    parameter int TIMEOUT    = 50_000_000,
    parameter int MAX_CREDIT = 3,
    localparam int CW   = $clog2(MAX_CREDIT + 1),
    localparam int COLW = $clog2(NCOL),
    localparam int TW   = $clog2(TIMEOUT),
    localparam int KW   = $clog2(CAM_CYCLES + 1)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            coin,
    input  logic [NCOL-2:0] sel,
    input  logic [NCOL-1:0] cam,
    input  logic [NCOL-1:0] soldout,
    output logic [NCOL-1:0] motor,
    output logic [NCOL-1:0] lamp,
    output logic [CW-1:0]   credit,
    output logic            busy,
    output logic            fault,
    output logic [COLW-1:0] fault_col
);

    typedef enum logic [2:0] {
        IDLE, CHECK, RUN_L, RUN_H, DONE, RELEASE, FAULT
    } state_t;

    state_t state_q, state_d;

    logic            coin_s1_q, coin_s2_q, coin_prev_q;
    logic [NCOL-2:0] sel_s1_q, sel_s2_q;
    logic [NCOL-1:0] cam_s1_q, cam_s2_q;
    logic [NCOL-1:0] so_s1_q, so_s2_q;

    logic [COLW-1:0] col_q, col_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   cams_q, cams_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic            fault_q, fault_d;
    logic [COLW-1:0] fcol_q, fcol_d;
    logic [NCOL-1:0] motor_q, motor_d;

    logic            coin_edge;
    logic [COLW-1:0] pick;
    logic [COLW-1:0] pick_col;
    logic [KW-1:0]   cams_inc;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            coin_s1_q   <= 1'b0;
            coin_s2_q   <= 1'b0;
            coin_prev_q <= 1'b0;
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
            cam_s1_q    <= '0;
            cam_s2_q    <= '0;
            so_s1_q     <= '0;
            so_s2_q     <= '0;
            state_q     <= IDLE;
            col_q       <= '0;
            cnt_q       <= '0;
            cams_q      <= '0;
            credit_q    <= '0;
            fault_q     <= 1'b0;
            fcol_q      <= '0;
            motor_q     <= '0;
        end else begin
            coin_s1_q   <= coin;
            coin_s2_q   <= coin_s1_q;
            coin_prev_q <= coin_s2_q;
            sel_s1_q    <= sel;
            sel_s2_q    <= sel_s1_q;
            cam_s1_q    <= cam;
            cam_s2_q    <= cam_s1_q;
            so_s1_q     <= soldout;
            so_s2_q     <= so_s1_q;
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            cams_q      <= cams_d;
            credit_q    <= credit_d;
            fault_q     <= fault_d;
            fcol_q      <= fcol_d;
            motor_q     <= motor_d;
        end
    end

    assign coin_edge = coin_s2_q & ~coin_prev_q;
    assign cams_inc  = cams_q + 1'b1;

    // Lowest-index pressed select wins; select 0 falls back to column 1.
    always_comb begin
        pick = '0;
        for (int k = NCOL - 2; k >= 0; k--) begin
            if (sel_s2_q[k]) pick = COLW'(k);
        end
        if (pick == '0) pick_col = so_s2_q[0] ? COLW'(1) : COLW'(0);
        else            pick_col = pick + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        cams_d   = cams_q;
        credit_d = credit_q;
        fault_d  = fault_q;
        fcol_d   = fcol_q;
        motor_d  = '0;

        if (coin_edge && state_q != FAULT && credit_q != CW'(MAX_CREDIT))
            credit_d = credit_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (credit_q != '0 && |sel_s2_q) begin
                    col_d   = pick_col;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (so_s2_q[col_q]) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d   = '0;
                    cams_d  = '0;
                    state_d = RUN_L;
                end
            end
            RUN_L: begin
                if (!cam_s2_q[col_q]) begin
                    cnt_d   = '0;
                    state_d = RUN_H;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    fcol_d  = col_q;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN_H: begin
                if (cam_s2_q[col_q]) begin
                    cams_d = cams_inc;
                    cnt_d  = '0;
                    if (cams_inc == KW'(CAM_CYCLES)) state_d = DONE;
                    else                             state_d = RUN_L;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    fcol_d  = col_q;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // A coin landing in this cycle cancels the decrement.
                if (!coin_edge) credit_d = credit_q - 1'b1;
                else            credit_d = credit_q;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!(|sel_s2_q)) state_d = IDLE;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        if (state_d == RUN_L || state_d == RUN_H)
            motor_d[col_d] = 1'b1;
    end

    always_comb begin
        lamp    = so_s2_q;
        lamp[0] = so_s2_q[0] & so_s2_q[1];
        lamp[1] = 1'b0;
    end

    assign motor     = motor_q;
    assign credit    = credit_q;
    assign fault     = fault_q;
    assign fault_col = fcol_q;
    assign busy      = (state_q == CHECK) || (state_q == RUN_L) ||
                       (state_q == RUN_H) || (state_q == DONE);

endmodule
